data_mem_responder: RTL and testbench

Memory-side responder for the processor's load/store port: accepts one word load or store request at a time from the memory-access stage and performs it against an internal word array after a configurable number of wait states. It returns a response with read data or an error flag, held under backpressure. It replaces a zero-latency data memory so the core and its verification can model realistic memory timing.

---
 rtl/riscdefs.sv | 38 +++
 rtl/data_mem_array.sv | 36 +++
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscdefs.sv
// Definitions shared by the data-memory responder and the processor's
// memory-access stage: FSM states, word size and access error codes.
package riscdefs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int WORD_BYTES = 4;

  localparam logic [1:0] MEM_ERR_NONE     = 2'd0;
  localparam logic [1:0] MEM_ERR_MISALIGN = 2'd1;
  localparam logic [1:0] MEM_ERR_RANGE    = 2'd2;

  // Range checks run on 33 bits so an address below base or near 2^32 cannot wrap into range.
  function automatic logic [1:0] mem_check(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span);
    logic [32:0] w_a;
    logic [32:0] w_b;
    logic [32:0] w_off;
    w_a   = {1'b0, addr};
    w_b   = {1'b0, base};
    w_off = w_a - w_b;
    if (addr[1:0] != 2'b00) begin
      mem_check = MEM_ERR_MISALIGN;
    end else if (w_a < w_b) begin
      mem_check = MEM_ERR_RANGE;
    end else if (w_off >= span) begin
      mem_check = MEM_ERR_RANGE;
    end else begin
      mem_check = MEM_ERR_NONE;
    end
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port DEPTH x 32 word array with synchronous write and registered read.
// The read register only changes on an enabled load, so it holds through backpressure.
module data_mem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Storage is deliberately left unreset.
  always_ff @(posedge Clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'h0000_0000;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one word request, waits WAIT_CYCLES, performs
// the access on the internal array and holds the response until it is taken.
module data_mem_responder
  import riscdefs::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH * WORD_BYTES);

  mem_state_t r_state;
  mem_state_t w_next_state;

  logic [3:0]    r_cnt;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic          r_rd_sel;

  logic          w_req_ready;
  logic          w_accept;
  logic          w_access;
  logic [1:0]    w_err_code;
  logic          w_err;
  logic          w_mem_en;
  logic [AW-1:0] w_index;
  logic [31:0]   w_mem_rdata;

  assign w_req_ready = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
  assign w_accept    = req_valid && w_req_ready;
  assign w_access    = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_err_code  = mem_check(r_addr, BASE_ADDR, SPAN);
  assign w_err       = (w_err_code != MEM_ERR_NONE);
  assign w_mem_en    = w_access && !w_err;
  assign w_index     = AW'((r_addr - BASE_ADDR) >> 2);

  data_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .Clk     (Clk),
    .reset   (reset),
    .i_en    (w_mem_en),
    .i_we    (r_we),
    .i_addr  (w_index),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A handshake in RESP with a pending request chains straight back into WAIT.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = WAIT;
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = RESP;
        end else begin
          w_next_state = WAIT;
        end
      end
      RESP: begin
        if (w_accept) begin
          w_next_state = WAIT;
        end else if (rsp_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_cnt   <= 4'd0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_cnt   <= 4'(WAIT_CYCLES);
    end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  // Read data itself sits in the array's read register; r_rd_sel gates it to zero for stores, errors and idle.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rd_sel    <= 1'b0;
    end else begin
      r_rsp_valid <= (w_next_state == RESP);
      if (w_access) begin
        r_rsp_err <= w_err;
        r_rd_sel  <= !w_err && !r_we;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_rsp_err <= 1'b0;
        r_rd_sel  <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rd_sel ? w_mem_rdata : 32'h0000_0000;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: u_dut_a (WAIT_CYCLES=2) runs the vector table and corner
// sequences, u_dut_b (WAIT_CYCLES=0) runs a continuous streaming sequence.
module tb_data_mem_responder;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        a_rst_n, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        b_rst_n, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) u_dut_a (
    .Clk(Clk), .reset(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) u_dut_b (
    .Clk(Clk), .reset(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];
  vec_t svec [7];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          idx, n_resp, last_cyc, k;
  logic        acc, started;
  int          q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at the negedge right after an accept edge; lat counts edges until rsp_valid.
  task automatic wait_valid(output int l);
    l = 0;
    while (!a_rsp_valid && l < 20) begin
      @(negedge Clk);
      l++;
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] r, output logic e, output int l);
    @(negedge Clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
    a_rsp_ready = 1'b1;
    @(negedge Clk);
    a_req_valid = 1'b0;
    wait_valid(l);
    r = a_rsp_rdata;
    e = a_rsp_err;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h0000_1234, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 32'h0000_1000, 32'h0000_0055, 32'h0000_0000, 1'b1};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_0011, 32'hBAD0_BAD0, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0040, 32'h1111_2222, 32'h0000_0000, 1'b0};

    svec[0] = '{1'b1, 32'h0000_0000, 32'h1111_0000, 32'h0000_0000, 1'b0};
    svec[1] = '{1'b1, 32'h0000_0004, 32'h2222_0004, 32'h0000_0000, 1'b0};
    svec[2] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1111_0000, 1'b0};
    svec[3] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'h2222_0004, 1'b0};
    svec[4] = '{1'b0, 32'h0000_0006, 32'h0000_0000, 32'h0000_0000, 1'b1};
    svec[5] = '{1'b1, 32'h0000_0000, 32'h3333_0000, 32'h0000_0000, 1'b0};
    svec[6] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h3333_0000, 1'b0};

    a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_rsp_ready = 1'b0;
    b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 32'h0; b_req_wdata = 32'h0; b_rsp_ready = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset a", {a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata}, {1'b0, 1'b1, 1'b0, 32'h0});
    check("reset b", {b_rsp_valid, b_req_ready, b_rsp_err, b_rsp_rdata}, {1'b0, 1'b1, 1'b0, 32'h0});
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d err", i), er, vecs[i].exp_err);
      check($sformatf("vec%0d latency", i), lat, 3);
    end

    // Backpressure: load 0x20 held for 5 cycles while a competing store is offered.
    @(negedge Clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h0000_0020; a_rsp_ready = 1'b0;
    @(negedge Clk);
    a_req_we = 1'b1; a_req_wdata = 32'h0000_9999;
    wait_valid(lat);
    check("hold latency", lat, 3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold cyc%0d", i), {a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata},
            {1'b1, 1'b0, 1'b0, 32'h0000_1234});
      @(negedge Clk);
    end
    a_req_valid = 1'b0; a_rsp_ready = 1'b1;
    @(negedge Clk);
    check("hold release idle", {a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata}, {1'b0, 1'b1, 1'b0, 32'h0});
    txn(1'b0, 32'h0000_0020, 32'h0, rd, er, lat);
    check("hold no accept", rd, 32'h0000_1234);

    // Reset one cycle after accepting a store: the store must be discarded.
    @(negedge Clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h0000_0040; a_req_wdata = 32'hAAAA_5555;
    @(negedge Clk);
    a_req_valid = 1'b0;
    check("rst pre wait", a_req_ready, 1'b0);
    a_rst_n = 1'b0;
    #1;
    check("rst async", {a_rsp_valid, a_req_ready}, {1'b0, 1'b1});
    @(negedge Clk);
    a_rst_n = 1'b1;
    txn(1'b0, 32'h0000_0040, 32'h0, rd, er, lat);
    check("rst store dropped", {er, rd}, {1'b0, 32'h1111_2222});

    // Back-to-back: second load accepted on the first response's handshake edge.
    @(negedge Clk);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h0000_0010; a_rsp_ready = 1'b1;
    @(negedge Clk);
    a_req_valid = 1'b0;
    wait_valid(lat);
    check("b2b first", {a_rsp_err, a_rsp_rdata}, {1'b0, 32'hDEAD_BEEF});
    a_req_valid = 1'b1; a_req_addr = 32'h0000_0020;
    @(negedge Clk);
    a_req_valid = 1'b0;
    check("b2b gap valid low", a_rsp_valid, 1'b0);
    wait_valid(lat);
    check("b2b latency", lat, 3);
    check("b2b second", {a_rsp_err, a_rsp_rdata}, {1'b0, 32'h0000_1234});

    // Streaming on the zero-wait instance with rsp_ready held high.
    @(negedge Clk);
    idx = 0; n_resp = 0; last_cyc = -1; started = 1'b0;
    b_req_valid = 1'b1; b_req_we = svec[0].we; b_req_addr = svec[0].addr; b_req_wdata = svec[0].wdata;
    acc = b_req_valid && b_req_ready;
    if (acc) begin q.push_back(0); started = 1'b1; end
    for (int cyc = 1; cyc <= 60 && n_resp < 7; cyc++) begin
      @(negedge Clk);
      if (b_rsp_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL stream spurious: response with nothing outstanding at cycle %0d", cyc);
        end else begin
          k = q.pop_front();
          check($sformatf("stream%0d rdata", k), b_rsp_rdata, svec[k].exp_rd);
          check($sformatf("stream%0d err", k), b_rsp_err, svec[k].exp_err);
          if (last_cyc >= 0) check($sformatf("stream%0d spacing", k), cyc - last_cyc, 2);
          last_cyc = cyc;
          n_resp++;
        end
      end
      if (started && b_req_valid) check($sformatf("stream ready cyc%0d", cyc), b_req_ready, b_rsp_valid);
      if (acc) begin
        idx++;
        if (idx < 7) begin
          b_req_we = svec[idx].we; b_req_addr = svec[idx].addr; b_req_wdata = svec[idx].wdata;
        end else begin
          b_req_valid = 1'b0;
        end
      end
      acc = b_req_valid && b_req_ready;
      if (acc) begin q.push_back(idx); started = 1'b1; end
    end
    check("stream count", n_resp, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
